// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader for fixed-latency RAMs, streamed out as AXI-Stream through a credit-tracked skid FIFO.
// Optional RAM_STREAM_READER_STALL_CNT_EN adds a saturating stall_cycles counter port.
module ram_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  output logic [31:0]           stall_cycles,
`endif
  output logic [WIDTH-1:0]      m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, iss_q, iss_d, wr_idx_q, wr_idx_d;
  logic [LATENCY-1:0]    vpipe_q, vpipe_d;
  logic [WIDTH:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  done_q, done_d;
  logic                  accept, issue, push, pop;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign ram_en        = busy;
  assign ram_we        = 1'b0;
  assign ram_addr      = addr_q;
  assign m_axis_tvalid = occ_q != '0;
  assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_q];
  // credits = FIFO_DEPTH - occupancy - inflight; a read is issued only while one is left
  always_comb begin
    accept   = state_q == IDLE && start && count != '0;
    issue    = state_q == RUN && (int'(occ_q) + $countones(vpipe_q) < FIFO_DEPTH);
    push     = vpipe_q[LATENCY-1];
    pop      = m_axis_tvalid && m_axis_tready;
    vpipe_d  = vpipe_q << 1;
    vpipe_d[0] = issue;
    state_d  = accept ? RUN
             : (issue && iss_q == cnt_q - 1'b1) ? DRAIN
             : (pop && m_axis_tlast) ? IDLE : state_q;
    addr_d   = accept ? base_addr
             : issue ? (addr_q == ADDR_WIDTH'(DEPTH - 1) ? '0 : addr_q + 1'b1) : addr_q;
    cnt_d    = accept ? count : cnt_q;
    iss_d    = accept ? '0 : iss_q + {{ADDR_WIDTH{1'b0}}, issue};
    wr_idx_d = accept ? '0 : wr_idx_q + {{ADDR_WIDTH{1'b0}}, push};
    done_d   = (state_q == IDLE && start && count == '0) || (pop && m_axis_tlast);
    wr_d     = push ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d     = pop ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    occ_d    = occ_q + OW'(push) - OW'(pop);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      iss_q    <= '0;
      wr_idx_q <= '0;
      vpipe_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      occ_q    <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      iss_q    <= iss_d;
      wr_idx_q <= wr_idx_d;
      vpipe_q  <= vpipe_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      occ_q    <= occ_d;
      done_q   <= done_d;
      if (push) mem_q[wr_q] <= {wr_idx_q == cnt_q - 1'b1, ram_dout};
    end
  end
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  logic [31:0] stall_q;
  assign stall_cycles = stall_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_q <= '0;
    else if (accept) stall_q <= '0;
    else if (busy && m_axis_tvalid && !m_axis_tready && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bursts against a 2-cycle RAM model with a queue-based stream scoreboard.
module tb_ram_stream_reader;
  localparam int W = 32, D = 64, AW = 6, L = 2, FD = 4;
  logic clk = 0, rstn = 0, start = 0, tready = 1;
  logic busy, done, ram_en, ram_we, tvalid, tlast;
  logic [AW-1:0] base_addr = '0, ram_addr;
  logic [AW:0] count = '0;
  logic [W-1:0] ram_dout, tdata;
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  logic [W-1:0] mem [D];
  logic [W-1:0] p0 = '0, p1 = '0;
  logic [W:0] exp_q [$];
  logic [W:0] e;
  int n_cmp = 0, n_bad = 0, beats = 0, stall_exp = 0;

  always #5 clk = ~clk;

  ram_stream_reader #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .LATENCY(L), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_dout(ram_dout),
`ifdef RAM_STREAM_READER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast));

  always @(posedge clk) if (ram_en) begin
    p0 <= mem[ram_addr];
    p1 <= p0;
  end
  assign ram_dout = p1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) if (rstn) begin
    if (busy && tvalid && !tready) stall_exp++;
    if (tvalid && tready) begin
      beats++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_unexpected: got %0h expected none", tdata);
      end else begin
        e = exp_q.pop_front();
        check("beat", {31'd0, tlast, tdata}, {31'd0, e});
      end
    end
  end

  task automatic start_burst(input int b, input int c, input bit push_exp);
    @(posedge clk) #1;
    if (push_exp) for (int i = 0; i < c; i++) exp_q.push_back({i == c - 1, mem[(b + i) % D]});
    start = 1; base_addr = AW'(b); count = (AW + 1)'(c);
    @(posedge clk) #1;
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 300);
    check({name, "_done"}, done, 1);
    check({name, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int lat, gaps, n;
    for (int i = 0; i < D; i++) mem[i] = W'(i + 100);
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {busy, done, ram_en, ram_we, tvalid, tlast, tdata, 26'(ram_addr)}, 0);
    @(negedge clk) rstn = 1;

    // contiguous burst, latency and back-to-back beats
    start_burst(5, 8, 1);
    @(negedge clk);
    lat = 0;
    while (!tvalid && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    check("first_latency", lat, L + 1);
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      if (!tvalid) gaps++;
      @(posedge clk); @(negedge clk);
    end
    check("beat_gaps", gaps, 0);
    check("burst1_done", done, 1);
    check("burst1_busy_low", busy, 0);
    @(negedge clk) check("done_single", done, 0);

    // wrap-around 62,63,0,1
    start_burst(62, 4, 1);
    wait_done("wrap");

    // backpressure
    @(posedge clk) #1 tready = 0;
    stall_exp = 0;
    start_burst(10, 16, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_tvalid", tvalid, 1);
    check("stall_head", tdata, 110);
    n = 0;
    while (!done && n < 300) begin @(posedge clk) #1 tready = ~tready; @(negedge clk); n++; end
    check("bp_done", done, 1);
`ifdef RAM_STREAM_READER_STALL_CNT_EN
    check("stall_cycles", stall_cycles, stall_exp);
`endif
    @(posedge clk) #1 tready = 1;

    // zero length
    start_burst(3, 0, 1);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    gaps = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (tvalid || busy || done) gaps++; end
    check("zero_quiet", gaps, 0);

    // ignored second start
    start_burst(20, 8, 1);
    @(posedge clk);
    start_burst(40, 3, 0);
    wait_done("ignored");
    repeat (4) @(negedge clk);
    check("ignored_tvalid", tvalid, 0);
    check("ignored_queue", exp_q.size(), 0);

    // reset mid-burst
    beats = 0;
    start_burst(0, 8, 1);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (beats < 3 && n < 100);
    check("three_beats", beats, 3);
    rstn = 0;
    #1 check("midrst_outputs", {busy, done, ram_en, tvalid, tlast, tdata, 26'(ram_addr)}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (3) @(negedge clk);
    check("post_reset_tvalid", tvalid, 0);
    beats = 0;
    start_burst(20, 2, 1);
    wait_done("after_reset");
    repeat (3) @(negedge clk);
    check("after_reset_beats", beats, 2);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
